// File: rtl/bios_loader_pkg.sv
// i281_pkg: shared widths, instruction field positions and loader state encoding.
package i281_pkg;
  localparam int INSTR_W = 17;
  localparam int IMEM_AW = 5;
  localparam int BIOS_AW = 4;
  localparam int MC_BIT  = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} ld_state_e;
endpackage

// File: rtl/bios_loader_if.sv
// bios_loader_if: instruction-memory write port plus 1-cycle-latency readback port.
interface bios_loader_if;
  import i281_pkg::*;
  logic               imem_wr_valid;
  logic               imem_wr_ready;
  logic [IMEM_AW-1:0] imem_wr_addr;
  logic [INSTR_W-1:0] imem_wr_data;
  logic [IMEM_AW-1:0] imem_rd_addr;
  logic [INSTR_W-1:0] imem_rd_data;
  modport master (output imem_wr_valid, imem_wr_addr, imem_wr_data, imem_rd_addr,
                  input  imem_wr_ready, imem_rd_data);
  modport slave  (input  imem_wr_valid, imem_wr_addr, imem_wr_data, imem_rd_addr,
                  output imem_wr_ready, imem_rd_data);
endinterface

// File: rtl/bios_loader_ctr.sv
// bios_loader_ctr: word index counter with clear priority over enable and a terminal-count flag.
module bios_loader_ctr #(
  parameter int W    = 5,
  parameter int LAST = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == W'(LAST);
endmodule

// File: rtl/bios_loader.sv
// bios_loader: copies NUM_WORDS BIOS ROM words into instruction memory while holding the CPU.
// Define BIOS_LOADER_VERIFY_EN to add a readback VERIFY pass with a sticky mismatch flag.
module bios_loader
  import i281_pkg::*;
#(
  parameter logic [IMEM_AW-1:0] BASE_ADDR = 5'd0,
  parameter int                 NUM_WORDS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [BIOS_AW-1:0] bios_addr,
  input  logic [INSTR_W-1:0] bios_word,
  bios_loader_if.master      imem,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               verify_err
);
`ifdef BIOS_LOADER_VERIFY_EN
  localparam ld_state_e AFTER_LOAD = S_VERIFY;
`else
  localparam ld_state_e AFTER_LOAD = S_DONE;
`endif
  ld_state_e          state_q, state_d;
  logic [IMEM_AW-1:0] idx;
  logic               tc, clr, en, in_load, start_acc;
  bios_loader_ctr #(.W(IMEM_AW), .LAST(NUM_WORDS - 1)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .en_i  (en),
    .cnt_o (idx),
    .tc_o  (tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      S_LOAD: begin
        en = imem.imem_wr_ready;
        if (imem.imem_wr_ready && tc) begin
          clr     = 1'b1;
          state_d = AFTER_LOAD;
        end
      end
`ifdef BIOS_LOADER_VERIFY_EN
      S_VERIFY: begin
        en = 1'b1;
        if (idx == IMEM_AW'(NUM_WORDS)) begin
          clr     = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: if (start) begin
        clr     = 1'b1;
        state_d = S_LOAD;
      end
    endcase
  end
  assign in_load            = state_q == S_LOAD;
  assign busy               = in_load || state_q == S_VERIFY;
  assign done               = state_q == S_DONE;
  assign cpu_hold           = !done;
  assign start_acc          = start && !busy;
  assign bios_addr          = busy ? idx[BIOS_AW-1:0] : '0;
  assign imem.imem_wr_valid = in_load;
  assign imem.imem_wr_addr  = in_load ? BASE_ADDR + idx : '0;
  assign imem.imem_wr_data  = in_load ? bios_word : '0;
`ifdef BIOS_LOADER_VERIFY_EN
  // Read data lags the address by a cycle, so the ROM word is delayed alongside it.
  logic [INSTR_W-1:0] exp_q;
  logic               chk_q, chk_d, verr_q, verr_d;
  assign chk_d  = state_q == S_VERIFY && idx < IMEM_AW'(NUM_WORDS);
  assign verr_d = start_acc ? 1'b0 : verr_q | (chk_q && imem.imem_rd_data != exp_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exp_q  <= '0;
      chk_q  <= 1'b0;
      verr_q <= 1'b0;
    end else begin
      exp_q  <= bios_word;
      chk_q  <= chk_d;
      verr_q <= verr_d;
    end
  assign imem.imem_rd_addr = state_q == S_VERIFY ? BASE_ADDR + idx : '0;
  assign verify_err        = verr_q;
`else
  assign imem.imem_rd_addr = '0;
  assign verify_err        = 1'b0;
`endif
endmodule

// File: tb/tb_bios_loader.sv
// tb_bios_loader: scoreboard bench; expected writes are queued at start and popped as the DUT writes.
module tb_bios_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start2 = 1'b0, rdy = 1'b1, corrupt = 1'b0;
  logic [3:0]  bios_addr, bios_addr2;
  logic [16:0] bios_word, bios_word2, mem [32], rd_q;
  logic cpu_hold, busy, done, verify_err, cpu_hold2, busy2, done2, verify_err2;
  int errors = 0, checks = 0;
  logic [21:0] sb [$];
  always #5 clk = ~clk;
  function automatic logic [16:0] rom_f(input logic [3:0] a);
    return a == 4'd1 ? 17'h1C01E : {a[0], ~a, a, a ^ 4'h9, a + 4'd3};
  endfunction
  bios_loader_if bus ();
  bios_loader_if bus2 ();
  assign bios_word  = rom_f(bios_addr);
  assign bios_word2 = rom_f(bios_addr2);
  assign bus.imem_wr_ready  = rdy;
  assign bus2.imem_wr_ready = rdy;
  assign bus.imem_rd_data   = rd_q;
  assign bus2.imem_rd_data  = 17'h0;
  always @(posedge clk) begin
    if (bus.imem_wr_valid && bus.imem_wr_ready)
      mem[bus.imem_wr_addr] <= (corrupt && bus.imem_wr_addr == 5'd5) ? bus.imem_wr_data ^ 17'h1 : bus.imem_wr_data;
    rd_q <= mem[bus.imem_rd_addr];
  end
  bios_loader #(.BASE_ADDR(5'd0), .NUM_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bios_addr(bios_addr), .bios_word(bios_word),
    .imem(bus.master), .cpu_hold(cpu_hold), .busy(busy), .done(done), .verify_err(verify_err));
  bios_loader #(.BASE_ADDR(5'd20), .NUM_WORDS(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bios_addr(bios_addr2), .bios_word(bios_word2),
    .imem(bus2.master), .cpu_hold(cpu_hold2), .busy(busy2), .done(done2), .verify_err(verify_err2));

  task automatic push_exp(input logic [4:0] base);
    for (int i = 0; i < 16; i++) sb.push_back({5'(base + 5'(i)), rom_f(4'(i))});
  endtask

  task automatic kick(input int inst);
    @(negedge clk);
    if (inst == 1) start2 = 1'b1; else start = 1'b1;
    push_exp(inst == 1 ? 5'd20 : 5'd0);
  endtask

  // mode 0: ready high; mode 1: ready 1,0,0,1 repeating; mode 2: ready high plus start pulses
  task automatic drain(input int inst, input int mode);
    int cyc = 0;
    logic stalled = 1'b0;
    logic [21:0] held = '0, e, got;
    logic v;
    while (sb.size() > 0 && cyc < 200) begin
      @(negedge clk);
      start2 = 1'b0;
      rdy    = mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      start  = mode == 2 && cyc % 3 == 1;
      v   = inst == 1 ? bus2.imem_wr_valid : bus.imem_wr_valid;
      got = inst == 1 ? {bus2.imem_wr_addr, bus2.imem_wr_data} : {bus.imem_wr_addr, bus.imem_wr_data};
      if (stalled) begin
        checks++;
        if ({v, got} !== {1'b1, held}) begin
          errors++;
          $display("FAIL stall_stable: got v=%b %h want v=1 %h", v, got, held);
        end
      end
      stalled = 1'b0;
      if (v && rdy) begin
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h want addr=%0d data=%h", got[21:17], got[16:0], e[21:17], e[16:0]);
        end
      end else if (v) begin
        stalled = 1'b1;
        held = got;
      end
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d writes missing, want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    rdy = 1'b1; start = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int inst);
    int n = 0;
    while (!(inst == 1 ? done2 : done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(inst == 1 ? done2 : done)) begin
      errors++;
      $display("FAIL done_timeout: done=0 want 1");
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({busy, done, cpu_hold, verify_err, bus.imem_wr_valid, bios_addr, bus.imem_wr_addr, bus.imem_rd_addr} !==
        {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0}) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b hold=%b verr=%b valid=%b baddr=%0d waddr=%0d raddr=%0d want 0 0 1 0 0 0 0 0",
               tag, busy, done, cpu_hold, verify_err, bus.imem_wr_valid, bios_addr, bus.imem_wr_addr, bus.imem_rd_addr);
    end
  endtask

  task automatic test_reset;
    #12 check_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle_after_reset");
  endtask

  task automatic test_main;
    kick(0);
    drain(0, 0);
`ifndef BIOS_LOADER_VERIFY_EN
    checks++;
    if ({done, cpu_hold, busy} !== 3'b100) begin
      errors++;
      $display("FAIL done_next_cycle: done=%b hold=%b busy=%b want 1 0 0", done, cpu_hold, busy);
    end
    checks++;
    if (verify_err !== 1'b0 || bus.imem_rd_addr !== 5'd0) begin
      errors++;
      $display("FAIL verify_tied: verr=%b raddr=%0d want 0 0", verify_err, bus.imem_rd_addr);
    end
`endif
    wait_done(0);
    checks++;
    if ({cpu_hold, busy, bus.imem_wr_valid} !== 3'b000) begin
      errors++;
      $display("FAIL done_outputs: hold=%b busy=%b valid=%b want 0 0 0", cpu_hold, busy, bus.imem_wr_valid);
    end
    checks++;
    if (mem[1] !== 17'h1C01E) begin
      errors++;
      $display("FAIL mem_addr1: got %h want 1c01e", mem[1]);
    end
  endtask

  task automatic test_stall;
    kick(0);
    drain(0, 1);
    wait_done(0);
  endtask

  task automatic test_base_wrap;
    kick(1);
    drain(1, 0);
    wait_done(1);
    checks++;
    if (bus2.imem_wr_valid !== 1'b0 || cpu_hold2 !== 1'b0) begin
      errors++;
      $display("FAIL base_done: valid=%b hold=%b want 0 0", bus2.imem_wr_valid, cpu_hold2);
    end
  endtask

  task automatic test_reset_midload;
    int n = 0, cyc = 0;
    kick(0);
    while (n < 7 && cyc < 50) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.imem_wr_valid && rdy) begin
        void'(sb.pop_front());
        n++;
      end
      cyc++;
    end
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL midload_progress: got %0d writes want 7", n);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset_midload");
    @(negedge clk) rst_n = 1'b1;
    sb.delete();
    kick(0);
    drain(0, 0);
    wait_done(0);
  endtask

  task automatic test_start_busy;
    kick(0);
    drain(0, 2);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.imem_wr_valid !== 1'b0) begin
        errors++;
        $display("FAIL extra_write: valid=%b want 0", bus.imem_wr_valid);
      end
      @(negedge clk);
    end
    wait_done(0);
  endtask

  task automatic test_verify;
`ifdef BIOS_LOADER_VERIFY_EN
    corrupt = 1'b1;
    kick(0);
    drain(0, 0);
    wait_done(0);
    checks++;
    if (verify_err !== 1'b1) begin
      errors++;
      $display("FAIL verify_detect: verr=%b want 1", verify_err);
    end
    corrupt = 1'b0;
    kick(0);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (verify_err !== 1'b0) begin
      errors++;
      $display("FAIL verify_clear_on_start: verr=%b want 0", verify_err);
    end
    sb.delete();
    push_exp(5'd0);
    for (int i = 0; i < 1; i++) void'(sb.pop_front());
    drain(0, 0);
    wait_done(0);
    checks++;
    if (verify_err !== 1'b0) begin
      errors++;
      $display("FAIL verify_clean: verr=%b want 0", verify_err);
    end
`else
    kick(0);
    drain(0, 0);
    wait_done(0);
    checks++;
    if (verify_err !== 1'b0) begin
      errors++;
      $display("FAIL verify_off: verr=%b want 0", verify_err);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_main;
    test_stall;
    test_base_wrap;
    test_reset_midload;
    test_start_busy;
    test_verify;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
